// File: rtl/line_fifo_reader.sv
// Read side of the line FIFO: drains one LINE_W-pixel line per line_start pulse and
// presents it on a valid/ready stream with sol/eol markers. A 2-entry skid absorbs the
// FIFO's registered read latency so a ready consumer sees one pixel per cycle.
module line_fifo_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LINE_W = 640,
  parameter int unsigned CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              line_done,
  output logic              busy,
  output logic              underflow,
  input  logic              clr_uflow
);

  localparam logic [CNT_W-1:0] LineLen = CNT_W'(LINE_W);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(LINE_W - 1);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] skid0_q, skid0_d;
  logic [DATA_W-1:0] skid1_q, skid1_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic              inflight_q;
  logic              underflow_q, underflow_d;

  logic       active;
  logic       pop;
  logic       push;
  logic [1:0] occ;
  logic       room;

  assign active = (state_q == StActive);
  assign pop    = pix_valid & pix_ready;
  assign push   = inflight_q;
  // Entries already held plus the one the FIFO is about to return.
  assign occ    = skid_cnt_q + {1'b0, inflight_q};
  // occ - pop < 2, written without a subtraction that could underflow.
  assign room   = (occ < 2'd2) || (pop && (occ == 2'd2));

  // Output decode from registered state; rd_en also sees fifo_empty and pix_ready.
  always_comb begin
    fifo_rd_en = active && !fifo_empty && (rd_cnt_q < LineLen) && room;
    pix_valid  = (skid_cnt_q != 2'd0);
    pix_data   = skid0_q;
    pix_sol    = pix_valid && (out_cnt_q == '0);
    pix_eol    = pix_valid && (out_cnt_q == LastIdx);
    line_done  = (state_q == StDone);
    busy       = (state_q != StIdle);
    underflow  = underflow_q;
  end

  // Line FSM and pixel counters.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      StIdle: begin
        if (line_start) begin
          state_d   = StActive;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      StActive: begin
        if (fifo_rd_en) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (pop) begin
          out_cnt_d = out_cnt_q + CNT_W'(1);
          if (out_cnt_q == LastIdx) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // In-order 2-entry skid; head always sits in skid0.
  always_comb begin
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (skid_cnt_q == 2'd0) skid0_d = fifo_data;
        else                    skid1_d = fifo_data;
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b01: begin
        skid0_d    = skid1_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          skid0_d = fifo_data;
        end else begin
          skid0_d = skid1_q;
          skid1_d = fifo_data;
        end
      end
      default: ;
    endcase
  end

  // Sticky underflow; a new event wins over a simultaneous clear.
  always_comb begin
    underflow_d = (active && pix_ready && !pix_valid) || (underflow_q && !clr_uflow);
  end

  // State register; async reset aborts any line in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      skid0_q     <= '0;
      skid1_q     <= '0;
      skid_cnt_q  <= 2'd0;
      inflight_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      skid_cnt_q  <= skid_cnt_d;
      inflight_q  <= fifo_rd_en;
      underflow_q <= underflow_d;
    end
  end

endmodule
